// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder fronting a single-ported backend: one AW+W or AR transaction in flight,
// fair write/read arbitration, one backend access each. Macro AXI_SLV_RANGE_CHECK_EN enables DECERR decoding.
module axi_lite_mem_slave #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(64'h1000_0000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awport,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arport,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  input  logic                    mem_err
);

  localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  // One extra bit so a window ending at the top of the address space does not wrap.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] addr_ext;
    addr_ext = {1'b0, addr};
    return !RANGE_CHECK || ((addr_ext >= WIN_LO) && (addr_ext < WIN_HI));
  endfunction

  typedef enum logic [2:0] {IDLE, W_ACC, W_MEM, BRESP, R_ACC, R_MEM, RRESP} state_t;

  state_t                  state_reg, state_next;
  logic                    last_read_reg;
  logic                    aw_got_reg, w_got_reg, in_win_reg;
  logic [ADDR_WIDTH-1:0]   addr_off_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg, rdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic [1:0]              bresp_reg, rresp_reg;

  logic aw_hs, w_hs, ar_hs, wr_pend, rd_pend, wr_in_window;
  logic unused_prot;

  assign unused_prot  = ^{awport, arport};
  assign aw_hs        = (state_reg == W_ACC) && awvalid && !aw_got_reg;
  assign w_hs         = (state_reg == W_ACC) && wvalid && !w_got_reg;
  assign ar_hs        = (state_reg == R_ACC) && arvalid;
  assign wr_pend      = awvalid || wvalid;
  assign rd_pend      = arvalid;
  // The address may arrive in the same cycle that completes the pair.
  assign wr_in_window = aw_hs ? in_window(awaddr) : in_win_reg;

  always_comb begin
    state_next = state_reg;
    awready    = 1'b0;
    wready     = 1'b0;
    arready    = 1'b0;
    bvalid     = 1'b0;
    rvalid     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_pend && (!rd_pend || last_read_reg)) state_next = W_ACC;
        else if (rd_pend)                           state_next = R_ACC;
      end
      W_ACC: begin
        awready = !aw_got_reg;
        wready  = !w_got_reg;
        if ((aw_got_reg || aw_hs) && (w_got_reg || w_hs))
          state_next = wr_in_window ? W_MEM : BRESP;
      end
      W_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_next = BRESP;
      end
      BRESP: begin
        bvalid = 1'b1;
        if (bready) state_next = IDLE;
      end
      R_ACC: begin
        arready = 1'b1;
        if (arvalid) state_next = in_window(araddr) ? R_MEM : RRESP;
      end
      R_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = RRESP;
      end
      RRESP: begin
        rvalid = 1'b1;
        if (rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_read_reg <= 1'b1;
      aw_got_reg    <= 1'b0;
      w_got_reg     <= 1'b0;
      in_win_reg    <= 1'b0;
      addr_off_reg  <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rdata_reg     <= '0;
      bresp_reg     <= RESP_OKAY;
      rresp_reg     <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next == W_ACC) last_read_reg <= 1'b0;
      if (state_reg == IDLE && state_next == R_ACC) last_read_reg <= 1'b1;

      if (aw_hs) begin
        aw_got_reg   <= 1'b1;
        addr_off_reg <= awaddr - BASE_ADDR;
        in_win_reg   <= in_window(awaddr);
      end
      if (w_hs) begin
        w_got_reg <= 1'b1;
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
      end
      if (state_reg == W_ACC && state_next == BRESP) bresp_reg <= RESP_DECERR;
      if (state_reg == W_MEM && mem_ack) bresp_reg <= mem_err ? RESP_SLVERR : RESP_OKAY;
      if (state_reg == BRESP && bready) begin
        aw_got_reg <= 1'b0;
        w_got_reg  <= 1'b0;
      end

      if (ar_hs) begin
        addr_off_reg <= araddr - BASE_ADDR;
        if (!in_window(araddr)) begin
          rresp_reg <= RESP_DECERR;
          rdata_reg <= '0;
        end
      end
      if (state_reg == R_MEM && mem_ack) begin
        rdata_reg <= mem_rdata;
        rresp_reg <= mem_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign bresp     = bresp_reg;
  assign rresp     = rresp_reg;
  assign rdata     = rdata_reg;
  assign mem_addr  = addr_off_reg;
  assign mem_wmask = wstrb_reg;
  assign mem_wdata = wdata_reg;

endmodule
